multi_clk_divider: RTL

//  NUM_CH-channel programmable clock divider; successor to the fixed single-output divider.

---
 rtl/clk_div_pkg.sv | 33 +++
 rtl/clk_div_channel.sv | 85 ++++++++
 rtl/multi_clk_divider.sv | 59 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    // Counter / half-period width used by every channel slice
    localparam int unsigned CFG_W  = 16;
    localparam int unsigned HP_MAX = (32'd1 << CFG_W) - 32'd1;

    // Per-channel configuration payload: half-period and phase offset
    typedef struct packed {
        logic [CFG_W-1:0] hp;
        logic [CFG_W-1:0] phase;
    } chan_cfg_t;

    // Register select on the write port
    typedef enum logic {
        SEL_HP    = 1'b0,
        SEL_PHASE = 1'b1
    } wr_sel_e;

    // Reset-default half-period in input cycles, clamped to 1..HP_MAX
    function automatic logic [CFG_W-1:0] def_hp(input int unsigned in_khz,
                                                 input int unsigned out_khz);
        int unsigned q;
        q = (out_khz == 32'd0) ? 32'd1 : in_khz / (32'd2 * out_khz);
        if (q == 32'd0) begin
            q = 32'd1;
        end else if (q > HP_MAX) begin
            q = HP_MAX;
        end
        return CFG_W'(q);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider slice: counter, active/shadow half-period, optional phase
// offset, registered out_clk and rise strobe.
// Optional feature: MULTI_CLK_DIVIDER_PHASE_EN adds the phase register.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter logic [CFG_W-1:0] DEF_HP = CFG_W'(26)
) (
    input  logic             in_clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_hp,
`ifdef MULTI_CLK_DIVIDER_PHASE_EN
    input  logic             wr_phase,
`endif
    input  logic [CFG_W-1:0] wr_data,
    output logic             out_clk,
    output logic             rise_stb
);

    logic [CFG_W-1:0] cnt_q;
    logic [CFG_W-1:0] act_hp_q;
    logic [CFG_W-1:0] shadow_hp_q;
    chan_cfg_t        cfg_c;
    logic [CFG_W-1:0] sync_cnt_c;
    logic             at_end_c;

    // Effective config this cycle: a same-cycle hp write is seen by sync/toggle
    assign cfg_c.hp = (wr_hp && (wr_data != '0)) ? wr_data : shadow_hp_q;

`ifdef MULTI_CLK_DIVIDER_PHASE_EN
    logic [CFG_W-1:0] phase_q;

    // Phase offset register; only consumed at the next sync
    always_ff @(posedge in_clk) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else if (wr_phase) begin
            phase_q <= wr_data;
        end
    end

    assign cfg_c.phase = phase_q;
`else
    assign cfg_c.phase = '0;
`endif

    // Sync start point clamped so the counter never exceeds A-1
    assign sync_cnt_c = (cfg_c.phase < cfg_c.hp) ? cfg_c.phase : cfg_c.hp - CFG_W'(1);
    assign at_end_c   = (cnt_q == act_hp_q - CFG_W'(1));

    // Counter, half-period registers and outputs; sync beats en, en beats counting
    always_ff @(posedge in_clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            act_hp_q    <= DEF_HP;
            shadow_hp_q <= DEF_HP;
            out_clk     <= 1'b0;
            rise_stb    <= 1'b0;
        end else begin
            shadow_hp_q <= cfg_c.hp;
            if (sync) begin
                cnt_q    <= sync_cnt_c;
                act_hp_q <= cfg_c.hp;
                out_clk  <= 1'b0;
                rise_stb <= 1'b0;
            end else if (!en) begin
                cnt_q    <= '0;
                act_hp_q <= cfg_c.hp;
                out_clk  <= 1'b0;
                rise_stb <= 1'b0;
            end else if (at_end_c) begin
                cnt_q    <= '0;
                act_hp_q <= cfg_c.hp;
                out_clk  <= ~out_clk;
                rise_stb <= ~out_clk;
            end else begin
                cnt_q    <= cnt_q + CFG_W'(1);
                rise_stb <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_clk_divider.sv
// NUM_CH-channel programmable clock divider with common phase-aligned restart.
// Optional feature: define MULTI_CLK_DIVIDER_PHASE_EN for per-channel phase offsets.
// CNT_W must match clk_div_pkg::CFG_W (the channel slice width).
module multi_clk_divider
    import clk_div_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 4,
    parameter  int unsigned CNT_W        = CFG_W,
    parameter  int unsigned IN_FREQ_KHZ  = 16000,
    parameter  int unsigned OUT_FREQ_KHZ = 300,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              in_clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic              wr_sel,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] rise_stb
);

    localparam logic [CFG_W-1:0] DEF_HP = def_hp(IN_FREQ_KHZ, OUT_FREQ_KHZ);

    logic hp_wr_c;

    // Register-select decode shared by all channels
    assign hp_wr_c = wr_en && (wr_sel_e'(wr_sel) == SEL_HP);

`ifdef MULTI_CLK_DIVIDER_PHASE_EN
    logic ph_wr_c;
    assign ph_wr_c = wr_en && (wr_sel_e'(wr_sel) == SEL_PHASE);
`endif

    // One slice per channel; out-of-range wr_ch matches no slice
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        logic hit_c;
        assign hit_c = (wr_ch == CH_W'(i));

        clk_div_channel #(
            .DEF_HP (DEF_HP)
        ) u_ch (
            .in_clk   (in_clk),
            .reset_n  (reset_n),
            .en       (en[i]),
            .sync     (sync),
            .wr_hp    (hp_wr_c && hit_c),
`ifdef MULTI_CLK_DIVIDER_PHASE_EN
            .wr_phase (ph_wr_c && hit_c),
`endif
            .wr_data  (wr_data),
            .out_clk  (out_clk[i]),
            .rise_stb (rise_stb[i])
        );
    end

endmodule
